// File: rtl/quote_pkg.sv
// Shared definitions for the quote frame receiver: default field widths,
// the receive state encoding and a decoded-quote record at default widths.
package quote_pkg;

    localparam int          TICKER_BYTES_DEF   = 4;
    localparam int          TS_BYTES_DEF       = 4;
    localparam int          PRICE_BYTES_DEF    = 3;
    localparam int          POS_BYTES_DEF      = 2;
    localparam int          TIMEOUT_DEFAULT    = 255;
    localparam int          FIFO_DEPTH_DEFAULT = 4;
    localparam logic [7:0]  SYNC_DEFAULT       = 8'hA5;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } rx_state_e;

    // Decoded quote at default widths, fields in frame order plus annotations.
    typedef struct packed {
        logic        [8*TICKER_BYTES_DEF-1:0] ticker;
        logic        [8*TS_BYTES_DEF-1:0]     timestamp;
        logic        [8*PRICE_BYTES_DEF-1:0]  ask;
        logic        [8*PRICE_BYTES_DEF-1:0]  bid;
        logic signed [8*POS_BYTES_DEF-1:0]    position;
        logic signed [8*PRICE_BYTES_DEF:0]    spread;
        logic                                 crossed;
    } quote_t;

endpackage

// File: rtl/quote_fifo.sv
// Show-ahead FIFO: dout always presents the head entry while not empty.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module quote_fifo
    import quote_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO, stored data becomes unreachable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage write; no reset needed because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/quote_frame_decoder.sv
// Byte-serial quote frame receiver: hunts for SYNC, assembles the payload,
// validates the XOR checksum, aborts stalled frames, and buffers decoded
// quotes (with spread and crossed flag) in a show-ahead FIFO.
// Output handshake: a quote transfers on every clock edge where
// out_valid && out_ready; out_valid never depends on out_ready and the
// head fields hold steady while out_valid && !out_ready.
module quote_frame_decoder
    import quote_pkg::*;
#(
    parameter int         TICKER_BYTES   = TICKER_BYTES_DEF,
    parameter int         TS_BYTES       = TS_BYTES_DEF,
    parameter int         PRICE_BYTES    = PRICE_BYTES_DEF,
    parameter int         POS_BYTES      = POS_BYTES_DEF,
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int         FIFO_DEPTH     = FIFO_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_byte,
    input  logic                         rx_valid,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [8*TICKER_BYTES-1:0]    out_ticker,
    output logic [8*TS_BYTES-1:0]        out_timestamp,
    output logic [8*PRICE_BYTES-1:0]     out_ask,
    output logic [8*PRICE_BYTES-1:0]     out_bid,
    output logic signed [8*POS_BYTES-1:0] out_position,
    output logic signed [8*PRICE_BYTES:0] out_spread,
    output logic                         out_crossed,
    output logic                         err_checksum,
    output logic                         err_timeout,
    output logic                         err_overflow,
    output logic [15:0]                  frames_ok,
    output logic [15:0]                  frames_bad
);

    localparam int PAYLOAD_BYTES = TICKER_BYTES + TS_BYTES + 2*PRICE_BYTES + POS_BYTES;
    localparam int PW    = 8*PAYLOAD_BYTES;
    localparam int TKW   = 8*TICKER_BYTES;
    localparam int TSW   = 8*TS_BYTES;
    localparam int PRW   = 8*PRICE_BYTES;
    localparam int POW   = 8*POS_BYTES;
    localparam int EW    = PW + PRW + 1;
    localparam int IDXW  = $clog2(PAYLOAD_BYTES + 1);
    localparam int IDLEW = $clog2(TIMEOUT_CYCLES + 1);

    rx_state_e         r_state;
    rx_state_e         w_state_next;
    logic [PW-1:0]     r_payload;
    logic [7:0]        r_xor;
    logic [IDXW-1:0]   r_idx;
    logic [IDLEW-1:0]  r_idle;
    logic [15:0]       r_frames_ok;
    logic [15:0]       r_frames_bad;
    logic              r_err_checksum;
    logic              r_err_timeout;
    logic              r_err_overflow;

    logic              w_idle_hit;
    logic              w_chk_match;
    logic              w_chk_bad;
    logic              w_timeout;
    logic              w_push;
    logic              w_pop;
    logic              w_overflow;
    logic              w_full;
    logic              w_empty;

    logic [TKW-1:0]    w_ticker;
    logic [TSW-1:0]    w_ts;
    logic [PRW-1:0]    w_ask;
    logic [PRW-1:0]    w_bid;
    logic [POW-1:0]    w_pos;
    logic [PRW:0]      w_spread;
    logic [EW-1:0]     w_din;
    logic [EW-1:0]     w_dout;
    logic [TKW-1:0]    w_h_ticker;
    logic [TSW-1:0]    w_h_ts;
    logic [PRW-1:0]    w_h_ask;
    logic [PRW-1:0]    w_h_bid;
    logic [POW-1:0]    w_h_pos;
    logic [PRW:0]      w_h_spread;

    // Field split of the fully assembled payload (first byte is MSB).
    assign {w_ticker, w_ts, w_ask, w_bid, w_pos} = r_payload;
    assign w_spread = {1'b0, w_ask} - {1'b0, w_bid};
    assign w_din    = {r_payload, w_spread};

    assign w_pop      = !w_empty && out_ready;
    assign w_push     = w_chk_match && (!w_full || w_pop);
    assign w_overflow = w_chk_match && w_full && !w_pop;
    assign w_idle_hit = (r_idle == IDLEW'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= HUNT;
        else     r_state <= w_state_next;
    end

    // Next-state and frame-outcome decode.
    always_comb begin
        w_state_next = r_state;
        w_chk_match  = 1'b0;
        w_chk_bad    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            HUNT: begin
                if (rx_valid && rx_byte == SYNC_BYTE) w_state_next = PAYLOAD;
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    if (r_idx == IDXW'(PAYLOAD_BYTES - 1)) w_state_next = CHECK;
                end else if (w_idle_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = HUNT;
                end
            end
            CHECK: begin
                if (rx_valid) begin
                    w_state_next = HUNT;
                    if (rx_byte == r_xor) w_chk_match = 1'b1;
                    else                  w_chk_bad   = 1'b1;
                end else if (w_idle_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = HUNT;
                end
            end
            default: w_state_next = HUNT;
        endcase
    end

    // Payload assembly, running XOR, byte index and idle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_payload <= '0;
            r_xor     <= '0;
            r_idx     <= '0;
            r_idle    <= '0;
        end else if (r_state == HUNT) begin
            r_xor  <= '0;
            r_idx  <= '0;
            r_idle <= '0;
        end else if (rx_valid) begin
            r_idle <= '0;
            if (r_state == PAYLOAD) begin
                r_payload <= {r_payload[PW-9:0], rx_byte};
                r_xor     <= r_xor ^ rx_byte;
                r_idx     <= r_idx + IDXW'(1);
            end
        end else begin
            r_idle <= r_idle + IDLEW'(1);
        end
    end

    // Saturating statistics and one-cycle error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frames_ok    <= '0;
            r_frames_bad   <= '0;
            r_err_checksum <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_err_checksum <= w_chk_bad;
            r_err_timeout  <= w_timeout;
            r_err_overflow <= w_overflow;
            if (w_push && r_frames_ok != 16'hFFFF)
                r_frames_ok <= r_frames_ok + 16'd1;
            if ((w_chk_bad || w_timeout || w_overflow) && r_frames_bad != 16'hFFFF)
                r_frames_bad <= r_frames_bad + 16'd1;
        end
    end

    quote_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    // Head fields are forced to zero while empty so reset shows all-zero outputs.
    assign {w_h_ticker, w_h_ts, w_h_ask, w_h_bid, w_h_pos, w_h_spread} = w_dout;
    assign out_valid     = !w_empty;
    assign out_ticker    = w_empty ? '0 : w_h_ticker;
    assign out_timestamp = w_empty ? '0 : w_h_ts;
    assign out_ask       = w_empty ? '0 : w_h_ask;
    assign out_bid       = w_empty ? '0 : w_h_bid;
    assign out_position  = w_empty ? '0 : w_h_pos;
    assign out_spread    = w_empty ? '0 : w_h_spread;
    assign out_crossed   = !w_empty && w_h_spread[PRW];
    assign err_checksum  = r_err_checksum;
    assign err_timeout   = r_err_timeout;
    assign err_overflow  = r_err_overflow;
    assign frames_ok     = r_frames_ok;
    assign frames_bad    = r_frames_bad;

endmodule

// File: tb/tb_quote_frame_decoder.sv
// Bench for quote_frame_decoder: directed vector table, multi-cycle corner
// sequences (timeout, overflow, full push/pop, reset mid-frame) and a random
// phase scored against a field-level reference model.
module tb_quote_frame_decoder;
    import quote_pkg::*;

    localparam int TO = TIMEOUT_DEFAULT;
    localparam int QW = $bits(quote_t);

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         rx_byte;
    logic               rx_valid;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_ticker;
    logic [31:0]        out_timestamp;
    logic [23:0]        out_ask;
    logic [23:0]        out_bid;
    logic signed [15:0] out_position;
    logic signed [24:0] out_spread;
    logic               out_crossed;
    logic               err_checksum;
    logic               err_timeout;
    logic               err_overflow;
    logic [15:0]        frames_ok;
    logic [15:0]        frames_bad;

    quote_frame_decoder #(
        .TICKER_BYTES   (4),
        .TS_BYTES       (4),
        .PRICE_BYTES    (3),
        .POS_BYTES      (2),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ticker    (out_ticker),
        .out_timestamp (out_timestamp),
        .out_ask       (out_ask),
        .out_bid       (out_bid),
        .out_position  (out_position),
        .out_spread    (out_spread),
        .out_crossed   (out_crossed),
        .err_checksum  (err_checksum),
        .err_timeout   (err_timeout),
        .err_overflow  (err_overflow),
        .frames_ok     (frames_ok),
        .frames_bad    (frames_bad)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    int n_pass  = 0;
    int n_total = 0;

    logic [QW-1:0] exp_q[$];
    int exp_ok = 0, exp_bad = 0;
    int exp_chk_err = 0, exp_to = 0, exp_ovf = 0;
    int cnt_chk = 0, cnt_to = 0, cnt_ovf = 0;
    bit rand_ready = 1'b0;
    logic [QW-1:0] mon_got;
    logic [QW-1:0] mon_exp;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: quote fields straight from the frame, spread by plain arithmetic.
    function automatic quote_t model_quote(input logic [31:0] t, input logic [31:0] ts,
                                           input logic [23:0] a, input logic [23:0] b,
                                           input logic [15:0] p);
        quote_t q;
        int     s;
        s           = int'(a) - int'(b);
        q.ticker    = t;
        q.timestamp = ts;
        q.ask       = a;
        q.bid       = b;
        q.position  = p;
        q.spread    = 25'(s);
        q.crossed   = (s < 0);
        return q;
    endfunction

    // Scoreboard: every accepted quote is compared with the expected queue head;
    // error pulses are counted (a stretched pulse counts more than once).
    always @(negedge clk) begin
        if (!rst) begin
            if (err_checksum) cnt_chk++;
            if (err_timeout)  cnt_to++;
            if (err_overflow) cnt_ovf++;
            if (out_valid && out_ready) begin
                mon_got = {out_ticker, out_timestamp, out_ask, out_bid,
                           out_position, out_spread, out_crossed};
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_quote: got %h expected none", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got === mon_exp) n_pass++;
                    else $display("FAIL quote: got %h expected %h", mon_got, mon_exp);
                end
            end
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Sends SYNC, payload and CHK; push_exp=0 means the quote is expected to overflow.
    task automatic send_frame(input logic [31:0] t, input logic [31:0] ts,
                              input logic [23:0] a, input logic [23:0] b,
                              input logic [15:0] p, input bit corrupt,
                              input bit push_exp, input bit ready_at_chk);
        logic [7:0] pl[16];
        logic [7:0] chk;
        for (int i = 0; i < 4; i++) pl[i]     = t[31-8*i -: 8];
        for (int i = 0; i < 4; i++) pl[4+i]   = ts[31-8*i -: 8];
        for (int i = 0; i < 3; i++) pl[8+i]   = a[23-8*i -: 8];
        for (int i = 0; i < 3; i++) pl[11+i]  = b[23-8*i -: 8];
        pl[14] = p[15:8];
        pl[15] = p[7:0];
        chk = 8'h00;
        for (int i = 0; i < 16; i++) chk ^= pl[i];
        if (corrupt) chk ^= 8'h01;
        send_byte(SYNC_DEFAULT);
        for (int i = 0; i < 16; i++) send_byte(pl[i]);
        if (corrupt) begin
            exp_bad++;
            exp_chk_err++;
        end else if (push_exp) begin
            exp_ok++;
            exp_q.push_back(model_quote(t, ts, a, b, p));
        end else begin
            exp_bad++;
            exp_ovf++;
        end
        if (ready_at_chk) out_ready = 1'b1;
        send_byte(chk);
    endtask

    // Stalls a frame after npay payload bytes and measures the timeout delay.
    task automatic timeout_case(input string name, input int npay);
        int waited;
        waited = 0;
        send_byte(SYNC_DEFAULT);
        for (int i = 0; i < npay; i++) send_byte(8'($urandom_range(0, 255)));
        exp_bad++;
        exp_to++;
        for (int c = 1; c <= TO + 5 && waited == 0; c++) begin
            tick();
            if (err_timeout) waited = c;
        end
        check({name, "_latency"}, waited, TO);
        check({name, "_bad"}, frames_bad, exp_bad);
        tick();
        check({name, "_pulse_end"}, err_timeout, 0);
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) tick();
        check({name, "_left"}, exp_q.size(), 0);
        tick();
        check({name, "_valid_off"}, out_valid, 0);
    endtask

    typedef struct {
        logic [31:0] ticker;
        logic [31:0] ts;
        logic [23:0] ask;
        logic [23:0] bid;
        logic [15:0] pos;
        bit          corrupt;
        int          garbage;
        bit          exp_valid;
        int          exp_spread;
        bit          exp_crossed;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] t, input logic [31:0] ts,
                                input logic [23:0] a, input logic [23:0] b,
                                input logic [15:0] p, input bit c, input int g,
                                input bit v, input int s, input bit x);
        vec_t r;
        r.ticker = t; r.ts = ts; r.ask = a; r.bid = b; r.pos = p;
        r.corrupt = c; r.garbage = g;
        r.exp_valid = v; r.exp_spread = s; r.exp_crossed = x;
        return r;
    endfunction

    vec_t       vecs[9];
    logic [7:0] garb[3];

    initial begin
        rst       = 1'b1;
        rx_byte   = 8'h00;
        rx_valid  = 1'b0;
        out_ready = 1'b1;

        vecs[0] = mk(32'h4141504C, 32'd1000, 24'd15025, 24'd15020, 16'hFFFB, 0, 0, 1, 5, 0);
        vecs[1] = mk(32'h4141504C, 32'd1000, 24'd15025, 24'd15020, 16'hFFFB, 1, 0, 0, 0, 0);
        vecs[2] = mk(32'h4141504C, 32'd1000, 24'd15025, 24'd15020, 16'hFFFB, 0, 3, 1, 5, 0);
        vecs[3] = mk(32'h4141504C, 32'd1000, 24'd15020, 24'd15025, 16'hFFFB, 0, 0, 1, -5, 1);
        vecs[4] = mk(32'h4D534654, 32'hFFFFFFFF, 24'hFFFFFF, 24'h000000, 16'h7FFF, 0, 0, 1, 16777215, 0);
        vecs[5] = mk(32'h474F4F47, 32'h0, 24'h000000, 24'hFFFFFF, 16'h8000, 0, 1, 1, -16777215, 1);
        vecs[6] = mk(32'hA5A5A5A5, 32'hA5A5A5A5, 24'h0000A5, 24'h0000A5, 16'hA5A5, 0, 0, 1, 0, 0);
        vecs[7] = mk(32'h000000A5, 32'h0, 24'h0, 24'h0, 16'h0, 0, 0, 1, 0, 0);
        vecs[8] = mk(32'h4141504C, 32'd1000, 24'd15025, 24'd15020, 16'hFFFB, 0, 0, 1, 5, 0);
        garb[0] = 8'h00;
        garb[1] = 8'hA4;
        garb[2] = 8'hFF;

        // Reset state.
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_ok", frames_ok, 0);
        check("rst_bad", frames_bad, 0);
        check("rst_errs", {err_checksum, err_timeout, err_overflow}, 0);
        check("rst_spread", out_spread, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            for (int g = 0; g < vecs[i].garbage; g++) send_byte(garb[g]);
            send_frame(vecs[i].ticker, vecs[i].ts, vecs[i].ask, vecs[i].bid, vecs[i].pos,
                       vecs[i].corrupt, 1'b1, 1'b0);
            check($sformatf("v%0d_valid", i), out_valid, vecs[i].exp_valid);
            check($sformatf("v%0d_chkerr", i), err_checksum, !vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_spread", i), out_spread, vecs[i].exp_spread);
                check($sformatf("v%0d_crossed", i), out_crossed, vecs[i].exp_crossed);
            end
            check($sformatf("v%0d_ok", i), frames_ok, exp_ok);
            check($sformatf("v%0d_bad", i), frames_bad, exp_bad);
            tick();
            check($sformatf("v%0d_valid_1cyc", i), out_valid, 0);
            check($sformatf("v%0d_chkerr_1cyc", i), err_checksum, 0);
        end

        // Timeout in PAYLOAD and in CHECK, each followed by a good frame.
        timeout_case("to_payload", 5);
        send_frame(32'h4141504C, 32'd1000, 24'd15025, 24'd15020, 16'hFFFB, 0, 1'b1, 1'b0);
        check("to_recover_valid", out_valid, 1);
        check("to_recover_ok", frames_ok, exp_ok);
        tick();
        timeout_case("to_check", 16);

        // Overflow: five frames with no consumer, fifth dropped, then ordered drain.
        out_ready = 1'b0;
        for (int f = 0; f < 5; f++)
            send_frame(32'h4141504C, 32'(f + 1), 24'd15025, 24'd15020, 16'hFFFB, 0, f < 4, 1'b0);
        check("ovf_pulse", err_overflow, 1);
        check("ovf_bad", frames_bad, exp_bad);
        check("ovf_ok", frames_ok, exp_ok);
        check("ovf_head", out_timestamp, 1);
        tick();
        check("ovf_pulse_end", err_overflow, 0);
        check("ovf_head_stable", out_timestamp, 1);
        drain("ovf_drain");

        // Full FIFO with push and pop on the same edge: both accepted.
        out_ready = 1'b0;
        for (int f = 0; f < 5; f++)
            send_frame(32'h4D534654, 32'(f + 10), 24'd200, 24'd100, 16'h0001, 0, 1'b1, f == 4);
        check("fullpp_no_ovf", err_overflow, 0);
        check("fullpp_ok", frames_ok, exp_ok);
        drain("fullpp_drain");

        // Reset mid-frame with buffered quotes: everything discarded.
        out_ready = 1'b0;
        send_frame(32'h474F4F47, 32'd5, 24'd7, 24'd9, 16'h0002, 0, 1'b1, 1'b0);
        send_frame(32'h474F4F47, 32'd6, 24'd7, 24'd9, 16'h0002, 0, 1'b1, 1'b0);
        send_byte(SYNC_DEFAULT);
        for (int i = 0; i < 8; i++) send_byte(8'h11);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ok", frames_ok, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_ok  = 0;
        exp_bad = 0;
        out_ready = 1'b1;
        tick();
        send_frame(32'h4141504C, 32'd1000, 24'd15025, 24'd15020, 16'hFFFB, 0, 1'b1, 1'b0);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_ok", frames_ok, 1);
        tick();

        // Random traffic: garbage, corrupted frames, back-to-back frames, random ready.
        rand_ready = 1'b1;
        for (int f = 0; f < 150; f++) begin
            int ng;
            ng = $urandom_range(0, 2);
            for (int g = 0; g < ng; g++) begin
                logic [7:0] b;
                b = 8'($urandom_range(0, 255));
                if (b == SYNC_DEFAULT) b = 8'h00;
                send_byte(b);
            end
            send_frame($urandom, $urandom, 24'($urandom), 24'($urandom), 16'($urandom),
                       $urandom_range(0, 3) == 0, 1'b1, 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_ready = 1'b0;
        drain("rand_drain");
        check("rand_ok", frames_ok, exp_ok);
        check("rand_bad", frames_bad, exp_bad);

        // Pulse totals across the whole run.
        check("pulses_chk", cnt_chk, exp_chk_err);
        check("pulses_to", cnt_to, exp_to);
        check("pulses_ovf", cnt_ovf, exp_ovf);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/quote_frame_decoder.md
# quote_frame_decoder

Parametrised market-quote frame receiver. It sits behind the byte-serial link (`rx_byte`/`rx_valid`) and in front of the trading algorithm. It hunts for a sync byte, assembles a fixed-layout quote frame, validates an XOR checksum and aborts stalled frames by timeout. Good frames are decoded, annotated with spread and crossed-market flags, and buffered in a small FIFO with a valid/ready output handshake.

## Interface
Parameters:
- `TICKER_BYTES`, 4: ticker field bytes, ASCII, MSB first
- `TS_BYTES`, 4: timestamp bytes, unsigned
- `PRICE_BYTES`, 3: bytes per ask and per bid, unsigned cents
- `POS_BYTES`, 2: position bytes, two's complement
- `SYNC_BYTE`, 8'hA5: frame start marker
- `TIMEOUT_CYCLES`, 255: maximum idle cycles allowed inside a frame, ≥1
- `FIFO_DEPTH`, 4: decoded-quote buffer entries, power of 2, ≥2

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock
- `rst` in 1: async active-high reset
- `rx_byte` in 8: incoming byte
- `rx_valid` in 1: `rx_byte` valid this cycle; no backpressure
- `out_valid` out 1: FIFO head holds a quote
- `out_ready` in 1: consumer accepts head
- `out_ticker` out 8·TICKER_BYTES
- `out_timestamp` out 8·TS_BYTES
- `out_ask`, `out_bid` out 8·PRICE_BYTES each
- `out_position` out 8·POS_BYTES signed
- `out_spread` out 8·PRICE_BYTES+1 signed: ask − bid
- `out_crossed` out 1: `out_spread` < 0
- `err_checksum`, `err_timeout`, `err_overflow` out 1 each: single-cycle pulses
- `frames_ok`, `frames_bad` out 16 each: saturating counters

## Operation
- Frame layout: SYNC, ticker, timestamp, ask, bid, position, CHK. PAYLOAD_BYTES = sum of the field bytes (16 by default), so a default frame is 18 bytes.
- CHK is the XOR of all payload bytes. SYNC is excluded from CHK.
- State machine (enum `HUNT`, `PAYLOAD`, `CHECK`):
  - HUNT: a valid byte equal to SYNC moves to PAYLOAD and clears `idx` and the running XOR. Any other byte is discarded silently.
  - PAYLOAD: each valid byte shifts into the payload register and is XORed into the running checksum; `idx`++. When the byte with `idx` == PAYLOAD_BYTES−1 is accepted, move to CHECK. A SYNC value inside the payload is treated as data.
  - CHECK: the next valid byte is compared with the running XOR.
    - Match: push the decoded quote into the FIFO and increment `frames_ok`.
    - Mismatch: pulse `err_checksum` and increment `frames_bad`.
    - Either way, return to HUNT. The CHK byte is never reinterpreted as SYNC.
- Timeout: an idle counter runs in PAYLOAD and CHECK and is cleared by every valid byte and on entry to PAYLOAD. When it reaches TIMEOUT_CYCLES, pulse `err_timeout`, increment `frames_bad`, and return to HUNT.
- Overflow: if the FIFO is full at push and there is no pop in that cycle, drop the new quote. Pulse `err_overflow` and increment `frames_bad`, not `frames_ok`. Push and pop on a full FIFO in the same cycle are both accepted.
- Spread: `spread` = zero-extend(ask) − zero-extend(bid), computed at push time and stored in the FIFO entry.
- Both counters saturate at 16'hFFFF.

## Timing
- Reset state: HUNT. FIFO empty. All outputs are 0, including both counters and all error pulses.
- Reset mid-frame discards the partial frame immediately. The FIFO contents are also lost.
- Latency: with the CHK byte sampled at edge N, the quote is written at edge N. If the FIFO was empty, `out_valid` = 1 during the cycle after edge N.
- The FIFO is show-ahead: the output fields are the head entry and are stable while `out_valid && !out_ready`. A pop occurs on any edge where `out_valid && out_ready`.
- Output fields are don't-care when `out_valid` = 0. The bench must not check them.
- Error pulses are asserted in the cycle after the triggering edge and last exactly 1 cycle.
- Throughput: one byte per cycle, back-to-back frames. A SYNC byte may immediately follow a CHK byte.

## Structure
- `quote_pkg`:
  - default width localparams
  - `SYNC_DEFAULT`
  - `rx_state_e` enum
  - `quote_t` packed struct for the default widths, used by the bench
- Sub-module `quote_fifo`:
  - synchronous show-ahead FIFO with parameters `WIDTH` and `DEPTH`
  - ports `push`/`pop`/`din`/`dout`/`full`/`empty`
  - async active-high `rst`
- The top-level module holds the state machine, the payload shift register, the XOR accumulator, the timeout counter and the statistics counters.

## Test plan
1. Good frame: A5, 41 41 50 4C, 00 00 03 E8, 00 3A B1, 00 3A AC, FF FB, EE, with `out_ready`=1. Expect:
   - `out_valid` for 1 cycle, one cycle after CHK
   - `out_ticker` = "AAPL", `out_timestamp` = 1000
   - `out_ask` = 15025, `out_bid` = 15020, `out_position` = −5
   - `out_spread` = 5, `out_crossed` = 0
   - `frames_ok` = 1
2. Same frame with CHK = EF: expect `err_checksum` pulse, `frames_bad` = 1, `out_valid` never asserted.
3. Three garbage bytes 00 A4 FF, then the good frame. Expect the garbage to be ignored and the quote decoded as in test 1.
4. Stop after 5 payload bytes and idle for TIMEOUT_CYCLES: expect `err_timeout`, then return to HUNT. A following good frame decodes correctly.
5. Swap ask and bid: `out_spread` = −5, `out_crossed` = 1.
6. Hold `out_ready`=0 and send 5 good frames. Expect the FIFO to fill with 4 quotes, the 5th to trigger `err_overflow` with `frames_bad` = 1, and the 4 quotes to drain in order once `out_ready`=1.
